// File: rtl/com_mmtx_pkg.sv
// rtl/com_mmtx_pkg.sv - shared word layout, write FSM states and helpers for com_mmtx
package com_mmtx_pkg;

    localparam int DATA_W  = 16;
    localparam int WORD_W  = 18;
    localparam int SOP_BIT = 17;
    localparam int EOP_BIT = 16;

    // Buffered word as seen by COM_MACTX; sop lands on SOP_BIT, eop on EOP_BIT.
    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } mmtx_word_t;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_PKT  = 2'd1;
    localparam logic [1:0] W_DROP = 2'd2;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/com_mmtx_dpram.sv
// rtl/com_mmtx_dpram.sv - simple dual-port RAM with registered read port
// Only the read register is reset; the array itself carries no reset.
module com_mmtx_dpram #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Holds the last word read while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/com_mmtx.sv
// rtl/com_mmtx.sv - store-and-forward TX packet buffer feeding COM_MACTX
// Packets are committed only when complete and well-formed; bad ones are rewound.
module com_mmtx
    import com_mmtx_pkg::*;
#(
    parameter int ADDR_W        = 9,
    parameter int MAX_PKT_WORDS = 256,
    parameter int MIN_PKT_WORDS = 3
) (
    input  logic              clk_12_5m,
    input  logic              rst_12_5m,
    input  logic [DATA_W-1:0] src_mmtx_data,
    input  logic              src_mmtx_sop,
    input  logic              src_mmtx_eop,
    input  logic              src_mmtx_wen,
    output logic              mmtx_src_rdy,
    input  logic              mactx_mmtx_rdreq,
    output logic [WORD_W-1:0] mmtx_mactx_data,
    output logic              mmtx_mactx_dval,
    output logic [7:0]        mmtx_drop_cnt
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int LEN_W = $clog2(MAX_PKT_WORDS + 2);
    // Depth also equals the pointer XOR pattern that signals full.
    localparam logic [PTR_W-1:0] DEPTH    = PTR_W'(2**ADDR_W);
    localparam logic [PTR_W-1:0] MAX_FREE = PTR_W'(MAX_PKT_WORDS);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PKT_WORDS);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PKT_WORDS);

    logic [1:0]        w_state, w_state_nxt;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]  wr_base, wr_base_nxt;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  pkt_cnt;
    logic [PTR_W-1:0]  used_words, free_words;
    logic [LEN_W-1:0]  wr_len, wr_len_nxt, len_inc;
    logic              full_at_ptr, full_at_base;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    mmtx_word_t        ram_wdata;
    logic              commit;
    logic [1:0]        drop_amt;
    logic              rd_busy;
    logic              issue, retire;

    assign full_at_ptr  = (wr_ptr  ^ rd_ptr) == DEPTH;
    assign full_at_base = (wr_base ^ rd_ptr) == DEPTH;
    assign len_inc      = wr_len + 1'b1;
    assign used_words   = wr_ptr - rd_ptr;
    assign free_words   = DEPTH - used_words;
    assign ram_wdata    = '{sop: src_mmtx_sop, eop: src_mmtx_eop, data: src_mmtx_data};

    always_comb begin
        w_state_nxt = w_state;
        wr_ptr_nxt  = wr_ptr;
        wr_base_nxt = wr_base;
        wr_len_nxt  = wr_len;
        ram_we      = 1'b0;
        ram_waddr   = wr_ptr[ADDR_W-1:0];
        commit      = 1'b0;
        drop_amt    = 2'd0;
        if (src_mmtx_wen) begin
            if (src_mmtx_sop) begin
                // A sop always restarts at the committed base, abandoning any open packet.
                wr_ptr_nxt = wr_base;
                if (w_state == W_PKT) begin
                    drop_amt = 2'd1;
                end
                if (src_mmtx_eop) begin
                    drop_amt    = drop_amt + 2'd1;
                    w_state_nxt = W_IDLE;
                end else if (full_at_base) begin
                    drop_amt    = drop_amt + 2'd1;
                    w_state_nxt = W_DROP;
                end else begin
                    ram_we      = 1'b1;
                    ram_waddr   = wr_base[ADDR_W-1:0];
                    wr_ptr_nxt  = wr_base + 1'b1;
                    wr_len_nxt  = LEN_W'(1);
                    w_state_nxt = W_PKT;
                end
            end else if (w_state == W_PKT) begin
                if (full_at_ptr || len_inc > MAX_LEN) begin
                    wr_ptr_nxt  = wr_base;
                    drop_amt    = 2'd1;
                    w_state_nxt = src_mmtx_eop ? W_IDLE : W_DROP;
                end else begin
                    ram_we     = 1'b1;
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    wr_len_nxt = len_inc;
                    if (src_mmtx_eop) begin
                        w_state_nxt = W_IDLE;
                        if (len_inc >= MIN_LEN) begin
                            commit      = 1'b1;
                            wr_base_nxt = wr_ptr + 1'b1;
                        end else begin
                            wr_ptr_nxt = wr_base;
                            drop_amt   = 2'd1;
                        end
                    end
                end
            end else if (w_state == W_DROP && src_mmtx_eop) begin
                w_state_nxt = W_IDLE;
            end
        end
    end

    // With one-cycle RAM latency the single outstanding read is exactly the dval
    // cycle, so gating on dval also enforces the idle gap between words.
    assign issue  = (pkt_cnt != '0 || rd_busy) && mactx_mmtx_rdreq && !mmtx_mactx_dval;
    // Packet flags are only known once the word leaves the RAM; retiring on dval
    // is safe because no new read can be issued in that cycle anyway.
    assign retire = mmtx_mactx_dval && mmtx_mactx_data[EOP_BIT];

    com_mmtx_dpram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_dpram (
        .clk   (clk_12_5m),
        .rst_n (rst_12_5m),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (issue),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mmtx_mactx_data)
    );

    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            w_state         <= W_IDLE;
            wr_ptr          <= '0;
            wr_base         <= '0;
            wr_len          <= '0;
            rd_ptr          <= '0;
            pkt_cnt         <= '0;
            rd_busy         <= 1'b0;
            mmtx_mactx_dval <= 1'b0;
            mmtx_src_rdy    <= 1'b0;
            mmtx_drop_cnt   <= 8'h00;
        end else begin
            w_state         <= w_state_nxt;
            wr_ptr          <= wr_ptr_nxt;
            wr_base         <= wr_base_nxt;
            wr_len          <= wr_len_nxt;
            mmtx_mactx_dval <= issue;
            mmtx_src_rdy    <= free_words >= MAX_FREE;
            mmtx_drop_cnt   <= sat_add8(mmtx_drop_cnt, drop_amt);
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (retire) begin
                rd_busy <= 1'b0;
            end else if (mmtx_mactx_dval && mmtx_mactx_data[SOP_BIT]) begin
                rd_busy <= 1'b1;
            end
            case ({commit, retire})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule
